// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding one shared FIFO, with credit-based full tracking.
// Optional FIFO_ARB_PRIO0_EN: requester 0 becomes strict high-priority.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = 5
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic [DW-1:0]       fifo_data,
    output logic                fifo_wrreq,
    input  logic                fifo_pop,
    output logic [CW-1:0]       credit_used,
    output logic [2:0]          grant_id,
    output logic                underflow_err
);

    logic [2:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [DW-1:0] data_q;
    logic          wrreq_q;
    logic [2:0]    gid_q;
    logic          uf_q, uf_d;

    logic          found;
    logic [2:0]    win;
    logic          credit_ok;
    logic          grant;
    logic          ptr_upd;

    // Winner search; the grant itself is qualified by credit and reset below.
    always_comb begin
        found   = 1'b0;
        win     = 3'd0;
        ptr_upd = 1'b1;
`ifdef FIFO_ARB_PRIO0_EN
        if (req_valid[0]) begin
            found   = 1'b1;
            win     = 3'd0;
            ptr_upd = 1'b0;
        end else begin
            for (int off = 0; off < N_REQ; off++) begin
                if (!found && (((int'(rr_ptr_q) + off) % N_REQ) != 0)
                        && req_valid[(int'(rr_ptr_q) + off) % N_REQ]) begin
                    found = 1'b1;
                    win   = 3'((int'(rr_ptr_q) + off) % N_REQ);
                end
            end
        end
`else
        for (int off = 0; off < N_REQ; off++) begin
            if (!found && req_valid[(int'(rr_ptr_q) + off) % N_REQ]) begin
                found = 1'b1;
                win   = 3'((int'(rr_ptr_q) + off) % N_REQ);
            end
        end
`endif
    end

    // Gating with rst guarantees no handshake completes during a reset cycle.
    assign credit_ok = (credit_q < CW'(DEPTH)) && !rst;
    assign grant     = found && credit_ok;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant && ptr_upd) begin
            rr_ptr_d = 3'((int'(win) + 1) % N_REQ);
        end
    end

    // A pop frees its credit only from the next cycle; grant+pop cancel out.
    always_comb begin
        credit_d = credit_q;
        uf_d     = uf_q;
        unique case ({grant, fifo_pop})
            2'b10: credit_d = credit_q + CW'(1);
            2'b01: begin
                if (credit_q == '0) begin
                    uf_d = 1'b1;
                end else begin
                    credit_d = credit_q - CW'(1);
                end
            end
            2'b11: begin
                if (credit_q == '0) begin
                    uf_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            rr_ptr_q <= 3'd0;
            credit_q <= '0;
            data_q   <= '0;
            wrreq_q  <= 1'b0;
            gid_q    <= 3'd0;
            uf_q     <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            credit_q <= credit_d;
            uf_q     <= uf_d;
            wrreq_q  <= grant;
            if (grant) begin
                data_q <= req_data[win*DW +: DW];
                gid_q  <= win;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            assert (credit_q <= CW'(DEPTH));
            assert ($onehot0(req_ready));
        end
    end
`endif

    assign fifo_data     = data_q;
    assign fifo_wrreq    = wrreq_q;
    assign credit_used   = credit_q;
    assign grant_id      = gid_q;
    assign underflow_err = uf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (N_REQ=4, DW=8, DEPTH=16).
// Expectations adapt when FIFO_ARB_PRIO0_EN is defined.
module tb_fifo_wr_arbiter;

`ifdef FIFO_ARB_PRIO0_EN
    localparam bit Prio = 1'b1;
`else
    localparam bit Prio = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  fifo_data;
    logic        fifo_wrreq;
    logic        fifo_pop;
    logic [4:0]  credit_used;
    logic [2:0]  grant_id;
    logic        underflow_err;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_wr_arbiter #(
        .N_REQ(4),
        .DW   (8),
        .DEPTH(16),
        .CW   (5)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_data    (fifo_data),
        .fifo_wrreq   (fifo_wrreq),
        .fifo_pop     (fifo_pop),
        .credit_used  (credit_used),
        .grant_id     (grant_id),
        .underflow_err(underflow_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".credit"}, 32'(credit_used), 32'd0);
        check({tag, ".wrreq"}, 32'(fifo_wrreq), 32'd0);
        check({tag, ".data"}, 32'(fifo_data), 32'd0);
        check({tag, ".gid"}, 32'(grant_id), 32'd0);
        check({tag, ".uf"}, 32'(underflow_err), 32'd0);
    endtask

    initial begin
        int w;
        rst       = 1'b1;
        req_valid = 4'h0;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        fifo_pop  = 1'b0;
        tick();
        req_valid = 4'hF;
        #1;
        check("ready_in_rst", 32'(req_ready), 32'd0);
        tick();
        check_reset_state("reset");

        // Fill from empty with all requesters valid, no pops.
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            w = Prio ? 0 : k % 4;
            #1;
            check($sformatf("fill_ready%0d", k), 32'(req_ready), 32'(4'b0001 << w));
            tick();
            check($sformatf("fill_wr%0d", k), 32'(fifo_wrreq), 32'd1);
            check($sformatf("fill_gid%0d", k), 32'(grant_id), 32'(w));
            check($sformatf("fill_data%0d", k), 32'(fifo_data), 32'(8'h11 * (w + 1)));
            check($sformatf("fill_cred%0d", k), 32'(credit_used), 32'(k + 1));
        end
        check("full_ready", 32'(req_ready), 32'd0);
        tick();
        check("full_wr", 32'(fifo_wrreq), 32'd0);
        check("full_cred", 32'(credit_used), 32'd16);

        // One pop at full: credit frees next cycle, exactly one more grant.
        fifo_pop = 1'b1;
        #1;
        check("pop_ready_same", 32'(req_ready), 32'd0);
        tick();
        fifo_pop = 1'b0;
        #1;
        check("pop_cred", 32'(credit_used), 32'd15);
        check("pop_ready", 32'(req_ready), 32'b0001);
        tick();
        check("pop_cred_back", 32'(credit_used), 32'd16);
        check("pop_gid", 32'(grant_id), 32'd0);
        check("pop_ready_after", 32'(req_ready), 32'd0);

        // Drain to 8, then grant and pop together.
        req_valid = 4'h0;
        fifo_pop  = 1'b1;
        repeat (8) tick();
        check("drain_cred", 32'(credit_used), 32'd8);
        req_valid = 4'hF;
        #1;
        w = Prio ? 0 : 1;
        check("gp_ready", 32'(req_ready), 32'(4'b0001 << w));
        tick();
        fifo_pop  = 1'b0;
        req_valid = 4'h0;
        check("gp_cred", 32'(credit_used), 32'd8);
        check("gp_data", 32'(fifo_data), 32'(8'h11 * (w + 1)));
        check("gp_wr", 32'(fifo_wrreq), 32'd1);

        // Pop at empty sets a sticky underflow flag.
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        fifo_pop = 1'b1;
        tick();
        fifo_pop = 1'b0;
        check("uf_cred", 32'(credit_used), 32'd0);
        check("uf_set", 32'(underflow_err), 32'd1);
        repeat (3) tick();
        check("uf_sticky", 32'(underflow_err), 32'd1);
        rst = 1'b1;
        tick();
        check("uf_clear", 32'(underflow_err), 32'd0);
        rst = 1'b0;

        // Lone requester 2.
        req_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
        req_valid = 4'b0100;
        #1;
        check("r2_ready", 32'(req_ready), 32'b0100);
        tick();
        check("r2_data", 32'(fifo_data), 32'hA5);
        check("r2_gid", 32'(grant_id), 32'd2);
        req_valid = 4'hF;
        #1;
        check("r2_next", 32'(req_ready), Prio ? 32'b0001 : 32'b1000);
        req_valid = 4'b1110;
        #1;
        check("r2_next_no0", 32'(req_ready), 32'b1000);
        tick();
        req_valid = 4'hF;
        tick();

        // Reset mid-stream.
        rst = 1'b1;
        #1;
        check("mid_ready_rst", 32'(req_ready), 32'd0);
        tick();
        check_reset_state("mid_rst");
        rst = 1'b0;
        #1;
        check("mid_ptr", 32'(req_ready), 32'b0001);

`ifdef FIFO_ARB_PRIO0_EN
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("p0_ready%0d", k), 32'(req_ready), 32'b0001);
            tick();
            check($sformatf("p0_gid%0d", k), 32'(grant_id), 32'd0);
        end
        req_valid = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("p0_rr%0d", k), 32'(req_ready), 32'(4'b0001 << ((k % 3) + 1)));
            tick();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one 16-entry synchronous FIFO among N_REQ producers. Each producer offers a word with a valid/ready handshake. The arbiter grants at most one producer per cycle and drives the FIFO write port from a register. It tracks FIFO occupancy with its own credit counter, so it never writes into a full FIFO and never depends on the FIFO's registered `full` flag.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DW`, 8: data width.
- `DEPTH`, 16: FIFO depth; the credit limit.
- `CW`, 5: credit counter width, must satisfy 2^CW > DEPTH.
- `clk_in` input 1: single clock, all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input N_REQ: bit i means requester i offers a word.
- `req_data` input N_REQ*DW: requester i's word is in bits [i*DW +: DW].
- `req_ready` output N_REQ: one-hot grant, combinational; a transfer occurs when `req_valid[i] && req_ready[i]`.
- `fifo_data` output DW: registered write data to the FIFO.
- `fifo_wrreq` output 1: registered write strobe to the FIFO.
- `fifo_pop` input 1: FIFO consumer popped an entry this cycle (rdreq && !empty).
- `credit_used` output CW: registered count of entries the arbiter believes are in the FIFO.
- `grant_id` output 3: registered index of the last granted requester.
- `underflow_err` output 1: sticky flag, set when `fifo_pop` arrives while `credit_used==0`.

## Operation
- Reset: `credit_used` = 0, round-robin pointer `rr_ptr` = 0, `fifo_wrreq` = 0, `fifo_data` = 0, `grant_id` = 0, `underflow_err` = 0, `req_ready` = 0.
- Grant condition: `credit_used < DEPTH` and at least one `req_valid` bit set.
  - A pop in the same cycle does not free a credit until the next cycle.
- Arbitration: search `req_valid` starting at index `rr_ptr`, wrapping modulo N_REQ.
  - The first set bit wins.
  - `req_ready` is one-hot on the winner and all zero when there is no grant.
- On a grant to requester w:
  - `rr_ptr <= (w+1) mod N_REQ`.
  - `fifo_data <= req_data[w]`, `fifo_wrreq <= 1`, `grant_id <= w`.
- With no grant: `fifo_wrreq <= 0`; `fifo_data` and `grant_id` hold their values; `rr_ptr` holds.
- Credit update, with g = grant and p = fifo_pop:
  - g only: +1.
  - p only: -1.
  - Both: unchanged.
  - p while the count is 0: count stays 0 and `underflow_err <= 1`. The flag clears only on `rst`.
- Requesters may drop `req_valid` at any time. There is no lock or hold, so an ungranted word is simply re-arbitrated.
- Reset mid-operation has priority over everything:
  - All state returns to reset values next cycle.
  - A write issued in the reset cycle is discarded; the FIFO must be reset alongside the arbiter.

## Timing
- Grant latency: 0 cycles. `req_ready` is combinational from `req_valid`, `rr_ptr` and `credit_used`.
- Write latency: a grant at cycle t gives `fifo_wrreq=1` and `fifo_data` at cycle t+1.
- `credit_used` reflects the grant or pop of cycle t from cycle t+1.
- Throughput: one word per cycle sustained while credits remain.
- At `credit_used==DEPTH`, `req_ready` is zero until the cycle after a pop.
- Fairness: a continuously valid requester waits at most N_REQ-1 grants.

## Configuration
- `FIFO_ARB_PRIO0_EN`:
  - Defined: requester 0 is strict high-priority. Whenever `req_valid[0]` is set and a credit exists, it wins regardless of `rr_ptr`, and `rr_ptr` is not updated on a requester-0 grant. Requesters 1..N_REQ-1 round-robin among themselves.
  - Undefined: all requesters share plain round-robin.

## Test plan
- Reset then all four requesters valid continuously, no pops -> grants in order 0,1,2,3,0,1,…; `fifo_wrreq` high cycles 1..16; after 16 grants `credit_used`=16 and `req_ready`=0.
- Full, then one `fifo_pop` pulse -> `credit_used` 16→15 next cycle; exactly one further grant, going to the next index in rotation; count returns to 16.
- Grant and pop in the same cycle at `credit_used`=8 -> `credit_used` stays 8; `fifo_data` equals the granted requester's word one cycle later.
- `fifo_pop` at `credit_used`=0 -> count stays 0 and `underflow_err`=1 until `rst`.
- Only requester 2 valid with data 0xA5 from reset -> `req_ready`=4'b0100 same cycle; `fifo_data`=0xA5 and `grant_id`=2 next cycle; then `rr_ptr`=3.
- `FIFO_ARB_PRIO0_EN` defined, all valid -> requester 0 granted every cycle until it drops valid; then 1,2,3 rotate. `rst` asserted mid-stream -> next cycle all outputs return to reset values.
